mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer sharing the 4:1 data mux between four requesters.
//   Grants one requester at a time and drives the mux select.
//   Registers the selected lane onto a single output bus with a valid flag.
//   Inserts one dead cycle between grants (break-before-make on the select).
// PARAMETERS
//   W         8   width of each requester data lane and of data_out
//   MAX_HOLD  8   max consecutive grant cycles per requester (legal 2..255); used only with HOLD_LIMIT_EN
// PORTS
//   clk       in   1    single clock, rising edge
//   rst       in   1    reset
//   ena       in   1    enable; 0 blocks new grants only
//   req       in   4    request per requester, level-sensitive
//   data_in   in   4*W  lane i = data_in[i*W +: W]
//   gnt       out  4    one-hot grant, registered
//   sel       out  2    mux select = index of granted/last-granted requester, registered
//   data_out  out  W    registered selected lane
//   valid     out  1    data_out holds lane data captured under an active grant
//   busy      out  1    FSM not in IDLE
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-high.
//   - Reset (async, immediate, also mid-grant) clears: gnt=0, sel=0, data_out=0, valid=0,
//     busy=0, ptr=0, hold_cnt=0, state=IDLE.
//   - State IDLE, ena=1, |req:
//     - winner = first set req bit scanning ptr, ptr+1, .. mod 4.
//     - Next edge: gnt=onehot(winner), sel=winner, hold_cnt=0, state=GRANT.
//     - Latency: req sampled at edge k -> gnt high after edge k.
//   - IDLE with ena=0 or req=0: outputs hold, gnt stays 0.
//   - State GRANT, each edge:
//     - data_out <= lane[sel]; valid <= 1.
//     - hold_cnt increments and saturates at 255.
//   - Release from GRANT at an edge where req[sel]==0 or (HOLD_LIMIT_EN and hold_cnt==MAX_HOLD-1):
//     - gnt<=0, ptr<=sel+1 mod 4 (3 wraps to 0), state<=GAP.
//     - That edge does not capture data; valid<=0.
//   - State GAP: one cycle, gnt=0, sel holds, valid=0, data_out holds its last value. Next edge -> IDLE.
//   - Release-to-next-grant = 3 edges (GAP, IDLE arbitrate, GRANT).
//   - ena deassert during GRANT/GAP: current grant runs to normal release; no new grant until ena=1.
//   - req changes of non-granted requesters during GRANT are ignored until next arbitration.
//   - A req bit that drops and re-rises during GAP is simply re-arbitrated in IDLE.
//   - busy=1 in GRANT and GAP; 0 in IDLE.
// CONFIGURATION
//   HOLD_LIMIT_EN defined:
//     - A grant is forcibly released after exactly MAX_HOLD GRANT cycles even if req stays high.
//     - Guarantees fairness: max wait = 3*(MAX_HOLD+2) cycles.
//   HOLD_LIMIT_EN undefined:
//     - Grant held until the requester deasserts; MAX_HOLD ignored.
//     - hold_cnt may be removed.
// TESTING
//   1. rst=1 with req=4'b1111, ena=1 -> gnt=0, sel=0, data_out=0, valid=0, busy=0; async clear mid-grant.
//   2. req=4'b0001, lane0=8'hA5 -> gnt=0001/sel=0 after 1 edge; valid=1, data_out=A5 after 2 edges.
//   3. HOLD_LIMIT_EN, MAX_HOLD=8, req=4'b1111 constant -> grants 0,1,2,3,0; each exactly 8 cycles,
//      1 GAP cycle between.
//   4. req=4'b0101, drop req[0] after 3 grant cycles -> gnt=0 next edge, GAP,
//      gnt=0100/sel=2 two edges later.
//   5. ena=0 with req=4'b0010 -> gnt stays 0; ena=0 mid-grant -> grant completes, no new grant;
//      ena=1 -> grant resumes.
//   6. ptr=3, req=4'b1001 -> requester 3 wins, then wrap to 0 on release.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Bus interface for mux_rr_arbiter: requester side (req/ena/lanes) and
// granted output side (gnt/sel/data_out/valid/busy).
interface mux_rr_arbiter_if #(
    parameter int W = 8
) ();
    logic           ena;
    logic [3:0]     req;
    logic [4*W-1:0] data_in;
    logic [3:0]     gnt;
    logic [1:0]     sel;
    logic [W-1:0]   data_out;
    logic           valid;
    logic           busy;

    modport master (
        output ena, req, data_in,
        input  gnt, sel, data_out, valid, busy
    );

    modport slave (
        input  ena, req, data_in,
        output gnt, sel, data_out, valid, busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 data mux, with a dead cycle between grants.
// Optional macro HOLD_LIMIT_EN forces release after MAX_HOLD grant cycles.
module mux_rr_arbiter #(
    parameter int W        = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst,
    mux_rr_arbiter_if.slave   bus
);

`ifdef HOLD_LIMIT_EN
    localparam logic HOLD_LIMIT = 1'b1;
`else
    localparam logic HOLD_LIMIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t       state_r, state_s;
    logic [1:0]   ptr_r, ptr_s;
    logic [7:0]   hold_cnt_r, hold_cnt_s;
    logic [3:0]   gnt_r, gnt_s;
    logic [1:0]   sel_r, sel_s;
    logic [W-1:0] data_r, data_s;
    logic         valid_r, valid_s;
    logic [1:0]   win_s;
    logic [W-1:0] lane_s;
    logic         release_s;

    // First requester at or after p, scanning upward modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign win_s     = rr_pick(bus.req, ptr_r);
    assign lane_s    = bus.data_in[sel_r*W +: W];
    // The limit term folds to zero when the hold limit is compiled out.
    assign release_s = !bus.req[sel_r] ||
                       (HOLD_LIMIT && (hold_cnt_r == 8'(MAX_HOLD - 1)));

    // Next-state and next-output logic for the grant sequencer.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        gnt_s      = gnt_r;
        sel_s      = sel_r;
        data_s     = data_r;
        valid_s    = valid_r;
        case (state_r)
            IDLE: begin
                if (bus.ena && (|bus.req)) begin
                    gnt_s      = 4'b0001 << win_s;
                    sel_s      = win_s;
                    hold_cnt_s = 8'd0;
                    state_s    = GRANT;
                end else begin
                    gnt_s = 4'b0000;
                end
            end
            GRANT: begin
                if (release_s) begin
                    gnt_s   = 4'b0000;
                    ptr_s   = sel_r + 2'd1;
                    valid_s = 1'b0;
                    state_s = GAP;
                end else begin
                    data_s  = lane_s;
                    valid_s = 1'b1;
                    if (hold_cnt_r != 8'hFF) begin
                        hold_cnt_s = hold_cnt_r + 8'd1;
                    end else begin
                        hold_cnt_s = hold_cnt_r;
                    end
                end
            end
            GAP: begin
                gnt_s   = 4'b0000;
                valid_s = 1'b0;
                state_s = IDLE;
            end
            default: begin
                gnt_s   = 4'b0000;
                valid_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= 2'd0;
            hold_cnt_r <= 8'd0;
            gnt_r      <= 4'b0000;
            sel_r      <= 2'd0;
            data_r     <= '0;
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            hold_cnt_r <= hold_cnt_s;
            gnt_r      <= gnt_s;
            sel_r      <= sel_s;
            data_r     <= data_s;
            valid_r    <= valid_s;
        end
    end

    assign bus.gnt      = gnt_r;
    assign bus.sel      = sel_r;
    assign bus.data_out = data_r;
    assign bus.valid    = valid_r;
    assign bus.busy     = (state_r != IDLE);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_mux_rr_arbiter;
    localparam int W        = 8;
    localparam int MAX_HOLD = 8;
`ifdef HOLD_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mux_rr_arbiter_if #(.W(W)) bus ();

    mux_rr_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: who owns the mux, how long, and cycles left in cooldown.
    int           m_owner;
    int           m_cool;
    int           m_age;
    int           m_ptr;
    logic [1:0]   m_sel;
    logic [W-1:0] m_data;
    logic         m_valid;

    function automatic logic [3:0] m_gnt();
        return (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    endfunction

    function automatic logic m_busy();
        return (m_owner >= 0) || (m_cool > 0);
    endfunction

    task automatic model_reset();
        m_owner = -1; m_cool = 0; m_age = 0; m_ptr = 0;
        m_sel = 2'd0; m_data = '0; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic e, input logic [4*W-1:0] d);
        int idx;
        if (m_owner >= 0) begin
            if (!r[m_owner] || (LIMIT && m_age == MAX_HOLD - 1)) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_cool  = 1;
                m_valid = 1'b0;
            end else begin
                m_data  = d[m_owner*W +: W];
                m_valid = 1'b1;
                if (m_age < 255) m_age++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (e && r != 4'b0000) begin
            for (int k = 3; k >= 0; k--) begin
                idx = (m_ptr + k) % 4;
                if (r[idx]) m_owner = idx;
            end
            m_sel = 2'(m_owner);
            m_age = 0;
        end
    endtask

    // One clock: inputs are stable at the edge; outputs settle #1 later.
    task automatic tick();
        logic [3:0]     r;
        logic           e;
        logic [4*W-1:0] d;
        r = bus.req; e = bus.ena; d = bus.data_in;
        @(posedge clk);
        model_step(r, e, d);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req = 4'b1111; bus.ena = 1'b1;
        bus.data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        model_reset();
        @(posedge clk); #1; @(posedge clk); #1;
        n_checks++;
        if ({bus.gnt, bus.sel, bus.data_out, bus.valid, bus.busy} !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_hold: gnt=%b sel=%0d data=%h valid=%b busy=%b required all zero",
                     bus.gnt, bus.sel, bus.data_out, bus.valid, bus.busy);
        end
        rst = 1'b0;
        tick(); tick();
        n_checks++;
        if (bus.valid !== 1'b1 || bus.data_out !== 8'h11) begin
            n_errors++;
            $display("FAIL pre_midreset: valid=%b data=%h required 1/11", bus.valid, bus.data_out);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({bus.gnt, bus.sel, bus.data_out, bus.valid, bus.busy} !== 16'h0) begin
            n_errors++;
            $display("FAIL async_midreset: gnt=%b sel=%0d data=%h valid=%b busy=%b required all zero",
                     bus.gnt, bus.sel, bus.data_out, bus.valid, bus.busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0001; bus.ena = 1'b1;
        bus.data_in = {8'h00, 8'h00, 8'h00, 8'hA5};
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0 || bus.valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_grant: gnt=%b sel=%0d valid=%b required 0001/0/0", bus.gnt, bus.sel, bus.valid);
        end
        tick();
        n_checks++;
        if (bus.valid !== 1'b1 || bus.data_out !== 8'hA5 || bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL single_data: valid=%b data=%h busy=%b required 1/a5/1", bus.valid, bus.data_out, bus.busy);
        end
        bus.req = 4'b0000;
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.valid !== 1'b0 || bus.busy !== 1'b1 || bus.data_out !== 8'hA5) begin
            n_errors++;
            $display("FAIL single_gap: gnt=%b valid=%b busy=%b data=%h required 0000/0/1/a5",
                     bus.gnt, bus.valid, bus.busy, bus.data_out);
        end
        tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.sel !== 2'd0) begin
            n_errors++;
            $display("FAIL single_idle: busy=%b sel=%0d required 0/0", bus.busy, bus.sel);
        end
    endtask

    task automatic test_drop();
        do_reset();
        bus.req = 4'b0101; bus.ena = 1'b1;
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0001) begin
            n_errors++;
            $display("FAIL drop_first: gnt=%b required 0001", bus.gnt);
        end
        tick(); tick(); tick();
        bus.req = 4'b0100;
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL drop_release: gnt=%b busy=%b required 0000/1", bus.gnt, bus.busy);
        end
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0000) begin
            n_errors++;
            $display("FAIL drop_idle: gnt=%b required 0000", bus.gnt);
        end
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0100 || bus.sel !== 2'd2) begin
            n_errors++;
            $display("FAIL drop_next: gnt=%b sel=%0d required 0100/2", bus.gnt, bus.sel);
        end
    endtask

    task automatic test_ena();
        do_reset();
        bus.req = 4'b0010; bus.ena = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL ena_block: gnt=%b busy=%b required 0000/0", bus.gnt, bus.busy);
        end
        bus.ena = 1'b1;
        tick();
        bus.ena = 1'b0;
        bus.req = 4'b0011;
        tick(); tick();
        n_checks++;
        if (bus.gnt !== 4'b0010) begin
            n_errors++;
            $display("FAIL ena_hold: gnt=%b required 0010", bus.gnt);
        end
        bus.req = 4'b0001;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL ena_nonew: gnt=%b busy=%b required 0000/0", bus.gnt, bus.busy);
        end
        bus.ena = 1'b1;
        tick();
        n_checks++;
        if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0) begin
            n_errors++;
            $display("FAIL ena_resume: gnt=%b sel=%0d required 0001/0", bus.gnt, bus.sel);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.req = 4'b0100; bus.ena = 1'b1;
        tick(); tick();
        bus.req = 4'b1001;
        tick(); tick(); tick();
        n_checks++;
        if (bus.gnt !== 4'b1000 || bus.sel !== 2'd3) begin
            n_errors++;
            $display("FAIL wrap_ptr3: gnt=%b sel=%0d required 1000/3", bus.gnt, bus.sel);
        end
        bus.req = 4'b0001;
        tick(); tick(); tick();
        n_checks++;
        if (bus.gnt !== 4'b0001 || bus.sel !== 2'd0) begin
            n_errors++;
            $display("FAIL wrap_to0: gnt=%b sel=%0d required 0001/0", bus.gnt, bus.sel);
        end
    endtask

`ifdef HOLD_LIMIT_EN
    task automatic test_hold_limit();
        int n;
        int hi;
        logic [3:0] g;
        do_reset();
        bus.req = 4'b1111; bus.ena = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (bus.gnt === 4'b0000 && n < 10) begin tick(); n++; end
            g = 4'b0001 << (k % 4);
            n_checks++;
            if (bus.gnt !== g) begin
                n_errors++;
                $display("FAIL hold_order%0d: gnt=%b required %b", k, bus.gnt, g);
            end
            hi = 0;
            while (bus.gnt === g && hi < 20) begin hi++; tick(); end
            n_checks++;
            if (hi != MAX_HOLD) begin
                n_errors++;
                $display("FAIL hold_len%0d: cycles=%0d required %0d", k, hi, MAX_HOLD);
            end
            n_checks++;
            if (bus.busy !== 1'b1 || bus.gnt !== 4'b0000) begin
                n_errors++;
                $display("FAIL hold_gap%0d: busy=%b gnt=%b required 1/0000", k, bus.busy, bus.gnt);
            end
            tick();
        end
    endtask
`else
    task automatic test_long_hold();
        do_reset();
        bus.req = 4'b0011; bus.ena = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (bus.gnt !== 4'b0001 || bus.valid !== 1'b1) begin
            n_errors++;
            $display("FAIL long_hold: gnt=%b valid=%b required 0001/1", bus.gnt, bus.valid);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) bus.req[b] = ~bus.req[b];
            bus.ena     = ($urandom_range(9) != 0);
            bus.data_in = {$urandom, $urandom} ;
            if ($urandom_range(400) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                @(posedge clk); #1;
                rst = 1'b0;
            end else begin
                tick();
            end
            n_checks++;
            if (bus.gnt !== m_gnt() || bus.sel !== m_sel || bus.data_out !== m_data ||
                bus.valid !== m_valid || bus.busy !== m_busy()) begin
                n_errors++;
                $display("FAIL random_c%0d: gnt=%b sel=%0d data=%h valid=%b busy=%b required %b/%0d/%h/%b/%b",
                         c, bus.gnt, bus.sel, bus.data_out, bus.valid, bus.busy,
                         m_gnt(), m_sel, m_data, m_valid, m_busy());
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_single();
        test_drop();
        test_ena();
        test_wrap();
`ifdef HOLD_LIMIT_EN
        test_hold_limit();
`else
        test_long_hold();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
